// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - decode-stage hazard, divide sequencing and flush control
module hazard_stall_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic        ex_valid_i,
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_is_div_i,
    input  logic        ex_redirect_i,
    output logic        pc_stall_o,
    output logic        ifid_stall_o,
    output logic        ifid_flush_o,
    output logic        idex_stall_o,
    output logic        idex_flush_o,
    output logic        exmem_bubble_o,
    output logic        div_start_o,
    output logic        div_busy_o,
    output logic        div_done_o,
    output logic [31:0] stall_cycles_o
);

    typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] div_cnt, div_cnt_nxt;
    logic             div_hit;
    logic             load_use;

    assign div_hit  = (state == IDLE) && ex_valid_i && ex_is_div_i;
    assign load_use = ex_valid_i && ex_mem_read_i && (ex_rd_addr_i != 5'd0) && id_valid_i &&
                      ((id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            div_cnt        <= '0;
            stall_cycles_o <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            if (pc_stall_o && (stall_cycles_o != 32'hFFFF_FFFF))
                stall_cycles_o <= stall_cycles_o + 32'd1;
        end
    end

    always_comb begin
        state_nxt      = state;
        div_cnt_nxt    = div_cnt;
        pc_stall_o     = 1'b0;
        ifid_stall_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_stall_o   = 1'b0;
        idex_flush_o   = 1'b0;
        exmem_bubble_o = 1'b0;
        div_start_o    = 1'b0;
        div_busy_o     = 1'b0;
        div_done_o     = 1'b0;

        if (rst) begin
            state_nxt   = IDLE;
            div_cnt_nxt = '0;
        end else if (div_hit || (state == DIV_RUN)) begin
            // The divider owns the pipeline: hold everything upstream, bubble downstream.
            pc_stall_o     = 1'b1;
            ifid_stall_o   = 1'b1;
            idex_stall_o   = 1'b1;
            exmem_bubble_o = 1'b1;
            if (div_hit) begin
                div_start_o = 1'b1;
                div_cnt_nxt = CNT_W'(DIV_CYCLES - 1);
                state_nxt   = DIV_RUN;
            end else begin
                div_busy_o = 1'b1;
                if (div_cnt == CNT_W'(1))
                    state_nxt = DIV_DONE;
                else
                    div_cnt_nxt = div_cnt - CNT_W'(1);
            end
        end else begin
            if (state == DIV_DONE) begin
                div_done_o = 1'b1;
                state_nxt  = IDLE;
            end
            // A redirect beats load-use: the stalled ID instruction is on the wrong path.
            if (ex_redirect_i) begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end else if (load_use) begin
                pc_stall_o   = 1'b1;
                ifid_stall_o = 1'b1;
                idex_flush_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_uses_rs1_i;
    logic        id_uses_rs2_i;
    logic        ex_valid_i;
    logic        ex_mem_read_i;
    logic [4:0]  ex_rd_addr_i;
    logic        ex_is_div_i;
    logic        ex_redirect_i;
    logic        pc_stall_o;
    logic        ifid_stall_o;
    logic        ifid_flush_o;
    logic        idex_stall_o;
    logic        idex_flush_o;
    logic        exmem_bubble_o;
    logic        div_start_o;
    logic        div_busy_o;
    logic        div_done_o;
    logic [31:0] stall_cycles_o;

    hazard_stall_ctrl #(.DIV_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .ex_valid_i(ex_valid_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_addr_i(ex_rd_addr_i),
        .ex_is_div_i(ex_is_div_i), .ex_redirect_i(ex_redirect_i),
        .pc_stall_o(pc_stall_o), .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o),
        .idex_stall_o(idex_stall_o), .idex_flush_o(idex_flush_o), .exmem_bubble_o(exmem_bubble_o),
        .div_start_o(div_start_o), .div_busy_o(div_busy_o), .div_done_o(div_done_o),
        .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] PC   = 9'b100000000;
    localparam logic [8:0] IFS  = 9'b010000000;
    localparam logic [8:0] IFF  = 9'b001000000;
    localparam logic [8:0] IDS  = 9'b000100000;
    localparam logic [8:0] IDF  = 9'b000010000;
    localparam logic [8:0] EXB  = 9'b000001000;
    localparam logic [8:0] DST  = 9'b000000100;
    localparam logic [8:0] BSY  = 9'b000000010;
    localparam logic [8:0] DNE  = 9'b000000001;
    localparam logic [8:0] LU   = PC | IFS | IDF;
    localparam logic [8:0] DSTL = PC | IFS | IDS | EXB;

    typedef struct {
        string       tag;
        logic [8:0]  ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cnt  = 32'd0;

    function automatic logic [8:0] obs_ctl();
        return {pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o,
                exmem_bubble_o, div_start_o, div_busy_o, div_done_o};
    endfunction

    task automatic clear_inputs();
        id_valid_i    = 1'b0;
        id_rs1_addr_i = 5'd0;
        id_rs2_addr_i = 5'd0;
        id_uses_rs1_i = 1'b0;
        id_uses_rs2_i = 1'b0;
        ex_valid_i    = 1'b0;
        ex_mem_read_i = 1'b0;
        ex_rd_addr_i  = 5'd0;
        ex_is_div_i   = 1'b0;
        ex_redirect_i = 1'b0;
    endtask

    // Inputs are already driven for this cycle; push the expectation, sample mid-cycle, advance.
    task automatic cyc(input string tag, input logic [8:0] ctl);
        exp_t e;
        exp_t got;
        e.tag = tag;
        e.ctl = ctl;
        e.cnt = exp_cnt;
        sb.push_back(e);
        if (rst)
            exp_cnt = 32'd0;
        else if (ctl[8] && exp_cnt != 32'hFFFF_FFFF)
            exp_cnt = exp_cnt + 32'd1;
        #2;
        got = sb.pop_front();
        checks++;
        assert (obs_ctl() === got.ctl) else begin
            failures++;
            $error("FAIL %s ctl observed=%b expected=%b", got.tag, obs_ctl(), got.ctl);
        end
        checks++;
        assert (stall_cycles_o === got.cnt) else begin
            failures++;
            $error("FAIL %s stall_cycles observed=%0d expected=%0d", got.tag, stall_cycles_o, got.cnt);
        end
        @(negedge clk);
    endtask

    task automatic set_load(input logic [4:0] rd);
        ex_valid_i    = 1'b1;
        ex_mem_read_i = 1'b1;
        ex_rd_addr_i  = rd;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        ex_valid_i  = 1'b1;
        ex_is_div_i = 1'b1;
        cyc("reset_forces_zero", NONE);
        rst = 1'b0;
        clear_inputs();
        cyc("idle", NONE);

        set_load(5'd5);
        id_valid_i = 1'b1; id_uses_rs1_i = 1'b1; id_rs1_addr_i = 5'd5;
        cyc("load_use_rs1", LU);
        clear_inputs();
        cyc("load_use_clears", NONE);

        set_load(5'd9);
        id_valid_i = 1'b1; id_uses_rs2_i = 1'b1; id_rs2_addr_i = 5'd9; id_rs1_addr_i = 5'd3; id_uses_rs1_i = 1'b1;
        cyc("load_use_rs2", LU);

        set_load(5'd0);
        id_valid_i = 1'b1; id_uses_rs1_i = 1'b1; id_rs1_addr_i = 5'd0; id_uses_rs2_i = 1'b0;
        cyc("load_rd_x0", NONE);

        set_load(5'd5);
        id_valid_i = 1'b1; id_uses_rs1_i = 1'b0; id_rs1_addr_i = 5'd0;
        cyc("lui_no_hazard", NONE);

        id_uses_rs1_i = 1'b1; id_rs1_addr_i = 5'd5; id_valid_i = 1'b0;
        cyc("id_bubble_no_hazard", NONE);

        id_valid_i = 1'b1; ex_redirect_i = 1'b1;
        cyc("redirect_over_load_use", IFF | IDF);
        clear_inputs();

        ex_valid_i = 1'b1; ex_is_div_i = 1'b1;
        cyc("div_T", DSTL | DST);
        set_load(5'd5); ex_is_div_i = 1'b1; ex_redirect_i = 1'b1;
        id_valid_i = 1'b1; id_uses_rs1_i = 1'b1; id_rs1_addr_i = 5'd5;
        cyc("div_T1_conflicts", DSTL | BSY);
        clear_inputs();
        ex_valid_i = 1'b1; ex_is_div_i = 1'b1;
        cyc("div_T2", DSTL | BSY);
        cyc("div_T3", DSTL | BSY);
        cyc("div_T4_done", DNE);
        cyc("div2_T5_start", DSTL | DST);
        cyc("div2_run1", DSTL | BSY);
        rst = 1'b1;
        cyc("reset_mid_div", NONE);
        rst = 1'b0;
        clear_inputs();
        cyc("after_reset_0", NONE);
        cyc("after_reset_1", NONE);
        cyc("after_reset_2", NONE);
        cyc("after_reset_3", NONE);

        set_load(5'd7);
        id_valid_i = 1'b1; id_uses_rs2_i = 1'b1; id_rs2_addr_i = 5'd7;
        cyc("load_use_after_reset", LU);
        clear_inputs();
        cyc("final_idle", NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the decode stage and the EX-stage M-extension divider. It detects load-use hazards between ID and EX and issues stall and bubble controls. It sequences multi-cycle DIV/DIVU/REM/REMU execution with an internal cycle counter and holds the front of the pipeline while the divider runs. It also applies EX-resolved branch/jump flushes and keeps a saturating stall-cycle performance counter.

Parameters:
DIV_CYCLES, 32, total EX occupancy of one divide in cycles; legal range 2..63.
CNT_W, 6, divide-counter width; must satisfy 2**CNT_W > DIV_CYCLES.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
id_valid_i  in  1  ID holds a real (non-bubble) instruction.
id_rs1_addr_i  in  5  ID rs1 address; already forced to x0 for LUI.
id_rs2_addr_i  in  5  ID rs2 address.
id_uses_rs1_i  in  1  ID instruction reads rs1.
id_uses_rs2_i  in  1  ID instruction reads rs2.
ex_valid_i  in  1  EX holds a real instruction.
ex_mem_read_i  in  1  EX instruction is a load.
ex_rd_addr_i  in  5  EX destination register.
ex_is_div_i  in  1  EX instruction is DIV/DIVU/REM/REMU.
ex_redirect_i  in  1  EX resolved a taken branch, JAL or JALR this cycle.
pc_stall_o  out  1  hold the PC.
ifid_stall_o  out  1  hold the IF/ID register.
ifid_flush_o  out  1  clear IF/ID to a bubble.
idex_stall_o  out  1  hold the ID/EX register.
idex_flush_o  out  1  load a bubble into ID/EX.
exmem_bubble_o  out  1  load a bubble into EX/MEM.
div_start_o  out  1  one-cycle pulse that starts the divider.
div_busy_o  out  1  divide in progress.
div_done_o  out  1  divider result valid this cycle; EX may advance.
stall_cycles_o  out  32  count of cycles with pc_stall_o=1, saturating.

Behaviour:
- Registered state: FSM {IDLE, DIV_RUN, DIV_DONE}, counter div_cnt[CNT_W-1:0], stall_cycles_o. All other outputs are combinational from state and inputs.
- Reset: state=IDLE, div_cnt=0, stall_cycles_o=0. While rst=1, every combinational output is forced to 0. A reset during DIV_RUN abandons the divide; no div_done_o is ever produced for it.
- div_hit = state==IDLE & ex_valid_i & ex_is_div_i.
- IDLE:
  - If div_hit: div_start_o=1; assert pc_stall, ifid_stall, idex_stall and exmem_bubble; set div_cnt<=DIV_CYCLES-1; next state DIV_RUN.
- DIV_RUN:
  - div_busy_o=1; assert pc_stall, ifid_stall, idex_stall and exmem_bubble.
  - If div_cnt==1, next state DIV_DONE; else div_cnt<=div_cnt-1.
- DIV_DONE:
  - div_done_o=1; no divide-related stall; next state IDLE unconditionally.
  - The divide leaves EX this cycle, so the next IDLE cycle sees a new instruction and never re-triggers.
- Timing: a divide first seen in EX at cycle T stalls cycles T..T+DIV_CYCLES-1 (exactly DIV_CYCLES cycles). div_done_o is high at T+DIV_CYCLES.
- load_use = ex_valid_i & ex_mem_read_i & (ex_rd_addr_i!=0) & id_valid_i & ((id_uses_rs1_i & id_rs1_addr_i==ex_rd_addr_i) | (id_uses_rs2_i & id_rs2_addr_i==ex_rd_addr_i)).
- Priority, highest first:
  - (1) div_hit, or state DIV_RUN: controls as above. load_use and ex_redirect_i are ignored; ID/EX is held, not flushed.
  - (2) ex_redirect_i: ifid_flush_o=1, idex_flush_o=1, pc_stall_o=0. This overrides load_use, because the stalled ID instruction is on the wrong path.
  - (3) load_use: pc_stall_o=1, ifid_stall_o=1, idex_flush_o=1. EX advances, so the stall lasts exactly one cycle per hazard.
  - (4) Otherwise all controls are 0.
- A stall and a flush of the same register are never asserted together.
- ex_is_div_i & ex_redirect_i together is a protocol violation; the divide wins.
- stall_cycles_o increments by 1 each cycle pc_stall_o=1 and holds at 0xFFFFFFFF.

Test Plan:
- Load-use: EX lw x5 (mem_read=1, rd=5), ID add x6,x5,x7 (uses rs1, rs1=5) -> one cycle with pc_stall=ifid_stall=idex_flush=1; next cycle all 0; stall_cycles_o=1.
- No false hazard: EX load with rd=0, or ID LUI with rs1=0 and uses_rs1=0 -> no stall.
- Divide, DIV_CYCLES=4: div_hit at T -> div_start_o only at T; stalls and exmem_bubble high at T..T+3; div_done_o=1 at T+4; IDLE at T+5; stall_cycles_o=4.
- Conflicts: redirect and load_use in the same cycle -> ifid_flush=idex_flush=1, pc_stall=0. load_use during DIV_RUN -> idex_stall=1, idex_flush=0.
- Back-to-back divides: a second div enters EX at T+5 -> new div_start_o at T+5 and no spurious start at T+4.
- Reset at T+2 of a divide -> next cycle state IDLE, all outputs 0, stall_cycles_o=0, and no div_done_o afterwards.
